result_writeback: RTL and testbench
===================================

Name: result_writeback

Overview:
- Downstream consumer of the accumulator array's per-lane results (8 lanes × 17-bit B-matrix row).
- Buffers completed rows in a small FIFO, serialises each row into 8 sign-extended 32-bit words, and writes them to B memory at consecutive word addresses.
- Counts rows against a programmed total, then signals done.

Parameters:
- LANES, 8, lanes per result row
- RES_W, 17, bits per lane result (two's complement)
- FIFO_DEPTH, 4, row entries buffered (power of two, ≥2)
- ADDR_W, 32, byte address width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse, begins job; ignored unless IDLE
- base_addr  input  ADDR_W  byte address of first word; sampled on start
- row_count  input  16  rows in job; sampled on start
- res_valid  input  1  result row presented
- res_data  input  LANES*RES_W  lane i at bits [i*RES_W +: RES_W]
- res_ready  output  1  row accepted when res_valid & res_ready
- mem_wr_en  output  1  write request
- mem_wr_addr  output  ADDR_W  byte address
- mem_wr_data  output  32  sign-extended lane value
- mem_wr_ready  input  1  write completes when mem_wr_en & mem_wr_ready
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when last word accepted
- overflow  output  1  sticky: a row was presented while FIFO full in RUN
- rows_written  output  16  rows fully written in current job

Behaviour:
- Async reset, all outputs/state: FSM=IDLE, FIFO empty, res_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, overflow=0, rows_written=0, lane ptr=0.
- FSM IDLE→RUN on start; latch base_addr into address counter, row_count into target; clear rows_written and overflow.
- start with row_count=0: go straight to DONE_ST; done pulses next cycle.
- RUN→DONE_ST when the final word of row (target−1) is accepted; DONE_ST asserts done for one cycle, then returns to IDLE.
- start in RUN or DONE_ST is ignored.
- Input side:
  - res_ready = (state==RUN) & FIFO not full & rows_accepted < target.
  - Accepted row pushed in the same edge.
  - Rows beyond target are not accepted (res_ready=0).
  - res_valid while in RUN & FIFO full sets overflow (sticky until next start or rst).
  - res_valid outside RUN has no effect.
- Output side:
  - mem_wr_en=1 whenever FIFO non-empty in RUN.
  - mem_wr_data = sign-extend(head lane[lane_ptr]) to 32 bits; mem_wr_addr = address counter.
  - Outputs are registered and must be stable while mem_wr_en & !mem_wr_ready.
  - On accept: address += 4 (modulo 2^ADDR_W, wraps silently); lane_ptr += 1.
  - On lane_ptr==LANES−1 accept: pop FIFO, lane_ptr=0, rows_written+=1.
  - Write latency: first mem_wr_en no earlier than the cycle after the row is accepted. Throughput is 1 word/cycle with mem_wr_ready held high, giving 8 cycles/row.
- Simultaneous push and pop on a full FIFO:
  - Push is refused; res_ready is computed from pre-edge full.
  - overflow is not set if res_ready was low only because of row limit.
- rst mid-job aborts immediately; no done. Partially written rows are not rolled back.

Test Plan:
- start base=0x1000, row_count=1; row lanes 0..7 = 1,2,…,8; mem_wr_ready=1 → 8 writes at 0x1000..0x101C, data 1..8; done 1 cycle after last; rows_written=1.
- Lane value 0x10000 (−65536), 0x1FFFF → mem_wr_data 0xFFFF0000, 0xFFFFFFFF; 0x0FFFF → 0x0000FFFF.
- row_count=6, mem_wr_ready=0, res_valid held high → 4 rows accepted; res_ready drops; overflow=1. Release ready → remaining 2 rows accepted; 48 writes; done once.
- Toggle mem_wr_ready every other cycle → addr/data stable while stalled; no word duplicated or skipped.
- base=0xFFFFFFF8, row_count=1 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …, 0x14.
- Assert rst after 3 words of row 0 → all outputs return to reset values immediately. A new start then runs cleanly from the newly latched base. Also, start with row_count=0 → done pulses, no writes.

Source files
------------

// File: rtl/result_writeback.sv
// Result writeback: buffers accumulator rows in a small FIFO and
// serialises each row into sign-extended 32-bit words for B memory.
module result_writeback #(
  parameter int LANES      = 8,
  parameter int RES_W      = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [15:0]            row_count,
  input  logic                   res_valid,
  input  logic [LANES*RES_W-1:0] res_data,
  output logic                   res_ready,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [31:0]            mem_wr_data,
  input  logic                   mem_wr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [15:0]            rows_written
);

  localparam int LW    = $clog2(LANES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int ROW_W = LANES * RES_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE_ST
  } state_t;

  state_t state, state_nx;

  logic [ROW_W-1:0]  fifo [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic [LW-1:0]     lane_ptr;
  logic [ADDR_W-1:0] addr_cnt;
  logic [15:0]       target;
  logic [15:0]       rows_acc;
  logic              last_word;

  logic             full, empty;
  logic             push, pop;
  logic             load, fire;
  logic             lane_end;
  logic             final_word;
  logic             job_start;
  logic [ROW_W-1:0] head;
  logic [RES_W-1:0] lane;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign res_ready = (state == RUN) && !full
                     && (rows_acc < target);
  assign push      = res_valid && res_ready;
  assign fire      = mem_wr_en && mem_wr_ready;

  // Output word register refills when empty or being accepted.
  assign load     = (state == RUN) && !empty
                    && (!mem_wr_en || mem_wr_ready);
  assign lane_end = (lane_ptr == LW'(LANES - 1));
  assign pop      = load && lane_end;

  assign final_word = fire && last_word
                      && (rows_written == target - 16'd1);
  assign job_start  = (state == IDLE) && start;

  assign head = fifo[rd_ptr];
  assign lane = head[lane_ptr*RES_W +: RES_W];

  assign busy = (state == RUN);
  assign done = (state == DONE_ST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (row_count == 16'd0) ? DONE_ST : RUN;
      end
      RUN: begin
        if (final_word)
          state_nx = DONE_ST;
      end
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lane_ptr     <= '0;
      addr_cnt     <= '0;
      target       <= '0;
      rows_acc     <= '0;
      rows_written <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nx;
      if (job_start) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        lane_ptr     <= '0;
        addr_cnt     <= base_addr;
        target       <= row_count;
        rows_acc     <= '0;
        rows_written <= '0;
        overflow     <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          rows_acc <= rows_acc + 16'd1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (!push && pop)
          count <= count - 1'b1;
        // A row blocked only by the row limit is not an overflow.
        if ((state == RUN) && res_valid && full
            && (rows_acc < target))
          overflow <= 1'b1;
        if (load) begin
          addr_cnt <= addr_cnt + ADDR_W'(4);
          lane_ptr <= lane_end ? '0 : lane_ptr + 1'b1;
        end
        if (fire && last_word)
          rows_written <= rows_written + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      last_word   <= 1'b0;
    end else if (load) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= addr_cnt;
      mem_wr_data <= {{(32-RES_W){lane[RES_W-1]}}, lane};
      last_word   <= lane_end;
    end else if (fire) begin
      mem_wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Randomised bench for result_writeback against a queue-based
// model of expected memory writes.
module tb_result_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] row_count;
  logic        res_valid;
  logic [135:0] res_data;
  logic        res_ready;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] rows_written;

  result_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_count    (row_count),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .rows_written (rows_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: sign extension by plain arithmetic
  function automatic logic [31:0] sext17(input logic [16:0] v);
    if (v >= 17'h10000)
      return 32'(v) - 32'h0002_0000;
    return 32'(v);
  endfunction

  logic [31:0] wq[$];
  logic [31:0] exp_addr;
  int          rows_acc;
  int          n_wr;
  int          done_cnt;
  logic        stalled;
  logic [31:0] p_addr, p_data;
  int          rdy_mode;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (res_valid && res_ready) begin
        for (int i = 0; i < 8; i++)
          wq.push_back(sext17(res_data[i*17 +: 17]));
        rows_acc++;
      end
      if (mem_wr_en) begin
        if (stalled) begin
          chk("hold_addr", mem_wr_addr, p_addr);
          chk("hold_data", mem_wr_data, p_data);
        end
        if (mem_wr_ready) begin
          if (wq.size() == 0) begin
            chk("extra_wr", 32'(n_wr), 32'hFFFF_FFFF);
          end else begin
            chk("wr_addr", mem_wr_addr, exp_addr);
            chk("wr_data", mem_wr_data, wq.pop_front());
          end
          exp_addr = exp_addr + 32'd4;
          n_wr++;
        end
      end
      stalled = mem_wr_en && !mem_wr_ready;
      p_addr  = mem_wr_addr;
      p_data  = mem_wr_data;
      if (done)
        done_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: mem_wr_ready = 1'b1;
      1: mem_wr_ready = ~mem_wr_ready;
      2: mem_wr_ready = 1'($urandom_range(0, 1));
      default: mem_wr_ready = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b,
                           input logic [15:0] n);
    exp_addr = b;
    wq.delete();
    rows_acc = 0;
    n_wr     = 0;
    done_cnt = 0;
    base_addr = b;
    row_count = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_rows(input int n, input int kind,
                           input int gap);
    logic [16:0] spec [8];
    logic [135:0] d;
    bit acc;
    int tmo;
    spec = '{17'h10000, 17'h1FFFF, 17'h0FFFF, 17'h0,
             17'h1, 17'h08000, 17'h07FFF, 17'h12345};
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 8; i++) begin
        case (kind)
          1: d[i*17 +: 17] = 17'(r*8 + i + 1);
          2: d[i*17 +: 17] = spec[i];
          default: d[i*17 +: 17] = 17'($urandom);
        endcase
      end
      res_valid = 1'b1;
      res_data  = d;
      tmo = 0;
      acc = 1'b0;
      while (!acc && tmo < 2000) begin
        @(negedge clk);
        acc = res_ready;
        step();
        tmo++;
      end
      if (!acc)
        chk("row_accept_timeout", 32'(r), 32'hFFFF_FFFF);
      res_valid = 1'b0;
      if (gap != 0)
        repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic wait_done(input int n, input int ovf_exp);
    int t = 0;
    while (done_cnt == 0 && t < 5000) begin
      step();
      t++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) step();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("rows_written", 32'(rows_written), 32'(n));
    chk("n_writes", 32'(n_wr), 32'(8*n));
    chk("q_empty", 32'(wq.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    if (ovf_exp >= 0)
      chk("overflow", 32'(overflow), 32'(ovf_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addr"}, mem_wr_addr, 32'd0);
    chk({tag, "_data"}, mem_wr_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_rows"}, 32'(rows_written), 32'd0);
    chk({tag, "_rdy"}, 32'(res_ready), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    res_valid = 1'b0;
    res_data = '0;
    mem_wr_ready = 1'b1;
    rdy_mode = 0;
    exp_addr = '0;
    rows_acc = 0;
    n_wr = 0;
    done_cnt = 0;
    stalled = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // single row, sequential lanes
    start_job(32'h0000_1000, 16'd1);
    send_rows(1, 1, 0);
    wait_done(1, 0);

    // sign extension boundaries
    start_job(32'h0000_4000, 16'd1);
    send_rows(1, 2, 0);
    wait_done(1, 0);

    // backpressure fills the FIFO, then drains
    rdy_mode = 3;
    start_job(32'h0000_5000, 16'd6);
    fork
      send_rows(6, 0, 0);
      begin
        repeat (20) step();
        chk("bp_rows_acc", 32'(rows_acc), 32'd4);
        chk("bp_res_ready", 32'(res_ready), 32'd0);
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_wr_en", 32'(mem_wr_en), 32'd1);
        chk("bp_no_writes", 32'(n_wr), 32'd0);
        rdy_mode = 0;
      end
    join
    wait_done(6, 1);

    // alternating ready
    rdy_mode = 1;
    start_job(32'h0000_6000, 16'd3);
    send_rows(3, 0, 0);
    wait_done(3, 0);

    // address wrap
    rdy_mode = 0;
    start_job(32'hFFFF_FFF8, 16'd1);
    send_rows(1, 0, 0);
    wait_done(1, 0);

    // random ready and gaps; a stray start mid-run is ignored
    rdy_mode = 2;
    start_job(32'h0001_0000, 16'd5);
    fork
      send_rows(5, 0, 1);
      begin
        repeat (5) step();
        base_addr = 32'hDEAD_0000;
        row_count = 16'd9;
        start = 1'b1;
        step();
        start = 1'b0;
      end
    join
    wait_done(5, -1);

    // reset mid-job, then a clean job
    rdy_mode = 0;
    start_job(32'h0000_2000, 16'd2);
    send_rows(1, 0, 0);
    begin
      int t = 0;
      while (n_wr < 3 && t < 200) begin
        step();
        t++;
      end
      chk("pre_rst_writes", 32'(n_wr), 32'd3);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    step();
    start_job(32'h0000_3000, 16'd1);
    send_rows(1, 0, 0);
    wait_done(1, 0);

    // zero-row job
    start_job(32'h0000_7000, 16'd0);
    wait_done(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
